uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter between `NUM_REQ` byte producers. It sits between the requesters and the `tx` module. It accepts one byte at a time and drives the transmitter's start/data inputs. It uses the transmitter's `tx_busy` level to decide when a frame has started and when it has finished. All logic runs on the system clock; the transmitter's baud-rate timing is seen only through `tx_busy`.

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between
// NUM_REQ byte producers.
//
// Handshakes:
//   req/ack  - a requester holds req[i] high with a stable byte until it sees
//              the one-cycle ack[i] pulse. Dropping req[i] before ack withdraws
//              the byte. A req[i] still high after ack is a new byte.
//   tx_start/tx_busy - tx_start is held high until tx_busy is sampled high.
//              The frame is then in flight until tx_busy is sampled low.
//              tx_busy is ignored while IDLE.
// dbg_state_o and dbg_ptr_o expose the FSM state (0 IDLE, 1 LAUNCH,
// 2 WAIT_DONE) and the round-robin pointer so that checkers can bind to them.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 1024,
  localparam int IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IdW-1:0]       grant_id,
  output logic                 grant_valid,
  output logic [1:0]           dbg_state_o,
  output logic [IdW-1:0]       dbg_ptr_o
);

  localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [IdW-1:0]       ptr_q;
  logic [TW-1:0]        timer_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 err_q;
  logic                 tx_start_q;
  logic [7:0]           tx_data_q;
  logic [IdW-1:0]       grant_id_q;
  logic                 grant_valid_q;

  logic                 grant_hit_d;
  logic [IdW-1:0]       grant_id_d;
  logic [7:0]           tx_data_d;

  // Index after id, wrapping at NUM_REQ (which need not be a power of two).
  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  // Round-robin search starting at ptr_q. The loop runs from the farthest
  // offset down, so the nearest requester is the one that wins.
  always_comb begin
    int             idx;
    logic [IdW-1:0] idx_w;
    grant_hit_d = 1'b0;
    grant_id_d  = '0;
    idx         = 0;
    idx_w       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = IdW'(idx);
      if (req[idx_w]) begin
        grant_hit_d = 1'b1;
        grant_id_d  = idx_w;
      end
    end
    tx_data_d = req_data[{grant_id_d, 3'b000} +: 8];
  end

  // Arbiter FSM with all outputs registered; pulses clear by default.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      timer_q       <= '0;
      ack_q         <= '0;
      done_q        <= '0;
      err_q         <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_hit_d) begin
            grant_id_q          <= grant_id_d;
            tx_data_q           <= tx_data_d;
            ack_q[grant_id_d]   <= 1'b1;
            tx_start_q          <= 1'b1;
            grant_valid_q       <= 1'b1;
            timer_q             <= '0;
            state_q             <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // tx_start stays up until the transmitter, which samples on its
          // baud tick, is seen busy. A busy pulse missed here times out.
          if (tx_busy) begin
            tx_start_q <= 1'b0;
            state_q    <= S_WAIT_DONE;
          end else if (timer_q == TIMER_LAST) begin
            err_q         <= 1'b1;
            tx_start_q    <= 1'b0;
            grant_valid_q <= 1'b0;
            ptr_q         <= next_id(grant_id_q);
            state_q       <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            done_q[grant_id_q] <= 1'b1;
            grant_valid_q      <= 1'b0;
            ptr_q              <= next_id(grant_id_q);
            state_q            <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign err         = err_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios drive requests and a
// transmitter model; ack/done/err events are matched against an expected queue.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic           tx_busy = 1'b0;
  logic [N-1:0]   ack;
  logic [N-1:0]   done;
  logic           err;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;
  logic           grant_valid;
  logic [1:0]     dbg_state;
  logic [1:0]     dbg_ptr;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .done        (done),
    .err         (err),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  // Event word: [15:12] kind (1 ack, 2 done, 3 err), [11:8] id, [7:0] byte.
  logic [15:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] oh_id(input logic [N-1:0] v);
    logic [3:0] r;
    r = 4'hF;
    if ($onehot(v)) begin
      for (int i = 0; i < N; i++) if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  task automatic mon_event(input string name, input logic [15:0] act);
    if (exp_q.size() == 0) check({name, "_unexpected"}, {16'h0, act}, 32'h0);
    else check(name, {16'h0, act}, {16'h0, exp_q.pop_front()});
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if ((|ack) === 1'b1)  mon_event("ack_event",  {4'h1, oh_id(ack), tx_data});
    if ((|done) === 1'b1) mon_event("done_event", {4'h2, oh_id(done), 8'h00});
    if (err === 1'b1)     mon_event("err_event",  {4'h3, 2'b00, grant_id, 8'h00});
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int id, input logic [7:0] b);
    req_data[id*8 +: 8] = b;
  endtask

  task automatic push_ack(input int id, input logic [7:0] b);
    exp_q.push_back({4'h1, 4'(id), b});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"},         {28'h0, ack},        32'h0);
    check({tag, "_done"},        {28'h0, done},       32'h0);
    check({tag, "_err"},         {31'h0, err},        32'h0);
    check({tag, "_tx_start"},    {31'h0, tx_start},   32'h0);
    check({tag, "_tx_data"},     {24'h0, tx_data},    32'h0);
    check({tag, "_grant_id"},    {30'h0, grant_id},   32'h0);
    check({tag, "_grant_valid"}, {31'h0, grant_valid}, 32'h0);
    check({tag, "_state"},       {30'h0, dbg_state},  32'h0);
    check({tag, "_ptr"},         {30'h0, dbg_ptr},    32'h0);
  endtask

  // Waits (bounded) for an ack; the grant must land exactly one edge later.
  task automatic wait_ack(input int id, input logic [7:0] b);
    int n;
    n = 0;
    while (n < 8) begin
      tick(1);
      n++;
      if ((|ack) === 1'b1) break;
    end
    check("ack_latency", n, 1);
    check("ack_vector", {28'h0, ack}, 32'(1) << id);
    check("ack_tx_data", {24'h0, tx_data}, {24'h0, b});
    check("ack_tx_start", {31'h0, tx_start}, 32'h1);
  endtask

  // Transmitter model: goes busy `rise` cycles after ack, stays busy `hold`.
  task automatic finish_frame(input int id, input logic [7:0] b, input int rise, input int hold);
    tick(rise);
    check("launch_tx_start_held", {31'h0, tx_start}, 32'h1);
    check("launch_line_byte", {24'h0, tx_data}, {24'h0, b});
    tx_busy = 1'b1;
    tick(1);
    check("busy_tx_start_low", {31'h0, tx_start}, 32'h0);
    check("busy_state", {30'h0, dbg_state}, 32'h2);
    tick(hold);
    tx_busy = 1'b0;
    exp_q.push_back({4'h2, 4'(id), 8'h00});
    tick(1);
    check("done_vector", {28'h0, done}, 32'(1) << id);
    check("done_grant_valid", {31'h0, grant_valid}, 32'h0);
    check("done_ptr", {30'h0, dbg_ptr}, 32'((id + 1) % N));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] bytes [N];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;

    tick(3);
    check_reset_values("reset");
    reset = 1'b0;

    // Single request from requester 2.
    set_byte(2, 8'hA5);
    req = 4'b0100;
    push_ack(2, 8'hA5);
    wait_ack(2, 8'hA5);
    req = 4'b0000;
    finish_frame(2, 8'hA5, 3, 4);

    // All four requesting continuously: grants 0,1,2,3,0.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_byte(i, bytes[i]);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      push_ack(g % N, bytes[g % N]);
      wait_ack(g % N, bytes[g % N]);
      if (g == 4) req = 4'b0000;
      finish_frame(g % N, bytes[g % N], 2, 3);
    end

    // Withdrawal: req[1] pulses while requester 0 is in flight.
    set_byte(0, 8'h5A);
    req = 4'b0001;
    push_ack(0, 8'h5A);
    wait_ack(0, 8'h5A);
    req = 4'b0010;
    tick(2);
    req = 4'b0000;
    finish_frame(0, 8'h5A, 1, 2);
    tick(3);
    check("withdraw_no_ack", {28'h0, ack}, 32'h0);
    check("withdraw_idle", {30'h0, dbg_state}, 32'h0);
    set_byte(3, 8'h77);
    req = 4'b1000;
    push_ack(3, 8'h77);
    wait_ack(3, 8'h77);
    req = 4'b0000;
    finish_frame(3, 8'h77, 2, 2);

    // Launch timeout: transmitter never goes busy.
    set_byte(2, 8'h3C);
    req = 4'b0100;
    push_ack(2, 8'h3C);
    wait_ack(2, 8'h3C);
    req = 4'b0000;
    tick(TO - 1);
    check("timeout_err_early", {31'h0, err}, 32'h0);
    check("timeout_start_held", {31'h0, tx_start}, 32'h1);
    exp_q.push_back({4'h3, 4'd2, 8'h00});
    tick(1);
    check("timeout_err", {31'h0, err}, 32'h1);
    check("timeout_tx_start", {31'h0, tx_start}, 32'h0);
    check("timeout_grant_valid", {31'h0, grant_valid}, 32'h0);
    check("timeout_no_done", {28'h0, done}, 32'h0);
    check("timeout_ptr", {30'h0, dbg_ptr}, 32'h3);
    check("timeout_state", {30'h0, dbg_state}, 32'h0);
    tick(1);
    check("timeout_err_pulse", {31'h0, err}, 32'h0);

    // Reset while a frame is in WAIT_DONE.
    set_byte(3, 8'h99);
    req = 4'b1000;
    push_ack(3, 8'h99);
    wait_ack(3, 8'h99);
    req = 4'b0000;
    tick(2);
    tx_busy = 1'b1;
    tick(1);
    check("midframe_state", {30'h0, dbg_state}, 32'h2);
    tick(2);
    reset = 1'b1;
    tick(1);
    check_reset_values("midframe_reset");
    reset = 1'b0;

    // Stale busy in IDLE with no requests: nothing moves.
    tick(4);
    check("stale_state", {30'h0, dbg_state}, 32'h0);
    check("stale_tx_start", {31'h0, tx_start}, 32'h0);
    check("stale_grant_valid", {31'h0, grant_valid}, 32'h0);
    check("stale_tx_data", {24'h0, tx_data}, 32'h0);
    tx_busy = 1'b0;
    tick(2);
    check("stale_no_done", {28'h0, done}, 32'h0);

    // Requester 3 alone after reset.
    set_byte(3, 8'hC3);
    req = 4'b1000;
    push_ack(3, 8'hC3);
    wait_ack(3, 8'hC3);
    req = 4'b0000;
    finish_frame(3, 8'hC3, 3, 4);

    tick(3);
    check("queue_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
